// File: rtl/ref_mem_pkg.sv
// -----------------------------------------------------------------------------
// ref_mem_pkg
// Shared definitions for the reference-window bank memory controller:
//   - ref_mem_state_e : controller state encoding (IDLE..DONE)
//   - DEF_*           : default values for the controller parameters
//   - grp_mask()      : builds the write strobe for one preload group
// -----------------------------------------------------------------------------
package ref_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_PRIME   = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_DONE    = 3'd4
    } ref_mem_state_e;

    localparam int DEF_NUM_BANKS       = 32;
    localparam int DEF_BANKS_PER_GROUP = 4;
    localparam int DEF_LINES_PER_GROUP = 96;
    localparam int DEF_ADDR_W          = 7;
    localparam int DEF_RD_ROWS         = 4;
    localparam int DEF_SEARCH_STEPS    = 64;

    // Widest bank count the mask helper supports; callers slice the low bits.
    localparam int MAX_BANKS = 256;

    // Strobe with bpg adjacent ones, shifted to the position of group grp.
    function automatic logic [MAX_BANKS-1:0] grp_mask(input int unsigned grp,
                                                      input int unsigned bpg);
        logic [MAX_BANKS-1:0] one_v;
        logic [MAX_BANKS-1:0] ones_v;
        one_v  = {{(MAX_BANKS-1){1'b0}}, 1'b1};
        ones_v = (one_v << bpg) - one_v;
        return ones_v << (grp * bpg);
    endfunction

endpackage

// File: rtl/ref_mem_line_cnt.sv
// -----------------------------------------------------------------------------
// ref_mem_line_cnt
// Two-level nested counter. The inner count runs 0..INNER_N-1; on its wrap the
// outer count advances through 0..OUTER_N-1 and wraps as well. With OUTER_N=1
// it is a plain single-level counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of both levels (priority over inc)
//   inc         : advance by one
//   inner_cnt   : inner count (full width)
//   outer_cnt   : outer count (full width)
//   inner_wrap  : inner count is at its last value
//   all_last    : both levels are at their last value
// -----------------------------------------------------------------------------
module ref_mem_line_cnt #(
    parameter int INNER_N = 96,
    parameter int OUTER_N = 8,
    parameter int IW      = 8,
    parameter int OW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] inner_cnt,
    output logic [OW-1:0] outer_cnt,
    output logic          inner_wrap,
    output logic          all_last
);

    logic [IW-1:0] inner_r;
    logic [OW-1:0] outer_r;
    logic          inner_last_s;
    logic          outer_last_s;

    assign inner_last_s = (inner_r == IW'(INNER_N - 1));
    assign outer_last_s = (outer_r == OW'(OUTER_N - 1));

    // Nested count register with clear priority and wrap on both levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner_r <= '0;
            outer_r <= '0;
        end else if (clr) begin
            inner_r <= '0;
            outer_r <= '0;
        end else if (inc) begin
            if (inner_last_s) begin
                inner_r <= '0;
                if (outer_last_s) begin
                    outer_r <= '0;
                end else begin
                    outer_r <= outer_r + OW'(1);
                end
            end else begin
                inner_r <= inner_r + IW'(1);
            end
        end else begin
            inner_r <= inner_r;
            outer_r <= outer_r;
        end
    end

    assign inner_cnt  = inner_r;
    assign outer_cnt  = outer_r;
    assign inner_wrap = inner_last_s;
    assign all_last   = inner_last_s && outer_last_s;

endmodule

// File: rtl/ref_win_mem_ctrl.sv
// -----------------------------------------------------------------------------
// ref_win_mem_ctrl
// Reference-window bank memory controller for integer motion estimation.
// Loads the search window into NUM_BANKS banks group by group (handshaked),
// primes the PE array with RD_ROWS rows, then issues one row read per pe_step
// until SEARCH_STEPS rows have been read, and pulses done.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a job (only honoured in IDLE)
//   abort          : synchronous return to IDLE, highest priority
//   wr_valid       : upstream line valid;  wr_ready : accepting lines
//   pe_step        : PE requests the next row (SEARCH only)
//   bank_sel       : per-bank write strobe
//   wr_addr_all    : per-bank write address (same address on all banks)
//   rd_addr_all    : per-bank read address (same address on all banks)
//   rd_en_n        : active-low read enable for all banks
//   rd_row_sel     : PE row slot that the current read data belongs to
//   busy           : job in progress;  done : one-cycle end-of-search pulse
//   perf_cycles    : busy-cycle counter
// Optional feature macro: REFMEM_PERF_EN enables the perf_cycles counter;
// without it perf_cycles is constant zero.
// All outputs are registered; commands appear the cycle after their trigger.
// -----------------------------------------------------------------------------
module ref_win_mem_ctrl
    import ref_mem_pkg::*;
#(
    parameter int NUM_BANKS       = DEF_NUM_BANKS,
    parameter int BANKS_PER_GROUP = DEF_BANKS_PER_GROUP,
    parameter int LINES_PER_GROUP = DEF_LINES_PER_GROUP,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int RD_ROWS         = DEF_RD_ROWS,
    parameter int SEARCH_STEPS    = DEF_SEARCH_STEPS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          pe_step,
    output logic [NUM_BANKS-1:0]          bank_sel,
    output logic [NUM_BANKS*ADDR_W-1:0]   wr_addr_all,
    output logic [NUM_BANKS*ADDR_W-1:0]   rd_addr_all,
    output logic                          rd_en_n,
    output logic [$clog2(RD_ROWS)-1:0]    rd_row_sel,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   perf_cycles
);

    localparam int NUM_GROUPS = NUM_BANKS / BANKS_PER_GROUP;
    localparam int GRP_W      = $clog2(NUM_GROUPS) + 1;
    localparam int LINE_W     = $clog2(LINES_PER_GROUP) + 1;
    localparam int STEP_W     = $clog2(SEARCH_STEPS) + 1;
    localparam int PRIME_W    = $clog2(RD_ROWS) + 1;
    localparam int RSW        = $clog2(RD_ROWS);
    localparam int AW_ALL     = NUM_BANKS * ADDR_W;

    ref_mem_state_e state_r, next_state_s;

    logic [NUM_BANKS-1:0] bank_sel_r,   bank_sel_nx_s;
    logic [AW_ALL-1:0]    wr_addr_r,    wr_addr_nx_s;
    logic [AW_ALL-1:0]    rd_addr_r,    rd_addr_nx_s;
    logic                 rd_en_n_r,    rd_en_n_nx_s;
    logic [RSW-1:0]       row_sel_r,    row_sel_nx_s;
    logic                 done_r,       done_nx_s;
    logic                 wr_ready_r;
    logic                 busy_r;

    logic                 start_acc_s;
    logic                 cnt_clr_s;
    logic                 wr_accept_s;
    logic                 prime_inc_s;
    logic                 step_inc_s;

    logic [LINE_W-1:0]    line_cnt_s;
    logic [GRP_W-1:0]     grp_cnt_s;
    logic                 line_all_last_s;
    logic                 line_wrap_unused_s;
    logic [PRIME_W-1:0]   prime_cnt_s;
    logic                 prime_last_s;
    logic                 prime_outer_unused_s;
    logic                 prime_wrap_unused_s;
    logic [STEP_W-1:0]    step_cnt_s;
    logic                 step_last_s;
    logic                 step_outer_unused_s;
    logic                 step_wrap_unused_s;

    logic [MAX_BANKS-1:0] grp_mask_full_s;
    logic                 grp_mask_unused_s;
    logic [ADDR_W-1:0]    search_row_s;

    assign start_acc_s = (state_r == ST_IDLE) && start && !abort;
    assign cnt_clr_s   = start_acc_s || abort;
    assign wr_accept_s = (state_r == ST_PRELOAD) && wr_valid && wr_ready_r && !abort;
    assign prime_inc_s = (state_r == ST_PRIME) && !abort;
    assign step_inc_s  = (state_r == ST_SEARCH) && pe_step && !abort;

    ref_mem_line_cnt #(
        .INNER_N (LINES_PER_GROUP),
        .OUTER_N (NUM_GROUPS),
        .IW      (LINE_W),
        .OW      (GRP_W)
    ) u_line_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr_s),
        .inc        (wr_accept_s),
        .inner_cnt  (line_cnt_s),
        .outer_cnt  (grp_cnt_s),
        .inner_wrap (line_wrap_unused_s),
        .all_last   (line_all_last_s)
    );

    ref_mem_line_cnt #(
        .INNER_N (RD_ROWS),
        .OUTER_N (1),
        .IW      (PRIME_W),
        .OW      (1)
    ) u_prime_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr_s),
        .inc        (prime_inc_s),
        .inner_cnt  (prime_cnt_s),
        .outer_cnt  (prime_outer_unused_s),
        .inner_wrap (prime_wrap_unused_s),
        .all_last   (prime_last_s)
    );

    ref_mem_line_cnt #(
        .INNER_N (SEARCH_STEPS),
        .OUTER_N (1),
        .IW      (STEP_W),
        .OW      (1)
    ) u_step_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr_s),
        .inc        (step_inc_s),
        .inner_cnt  (step_cnt_s),
        .outer_cnt  (step_outer_unused_s),
        .inner_wrap (step_wrap_unused_s),
        .all_last   (step_last_s)
    );

    assign grp_mask_full_s   = grp_mask(32'(grp_cnt_s), 32'(BANKS_PER_GROUP));
    assign grp_mask_unused_s = ^grp_mask_full_s[MAX_BANKS-1:NUM_BANKS];
    // Search rows start right after the primed rows.
    assign search_row_s      = ADDR_W'(RD_ROWS) + ADDR_W'(step_cnt_s);

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        next_state_s  = state_r;
        bank_sel_nx_s = '0;
        wr_addr_nx_s  = wr_addr_r;
        rd_addr_nx_s  = rd_addr_r;
        rd_en_n_nx_s  = 1'b1;
        row_sel_nx_s  = row_sel_r;
        done_nx_s     = 1'b0;
        if (abort) begin
            next_state_s = ST_IDLE;
            wr_addr_nx_s = '0;
            rd_addr_nx_s = '0;
            row_sel_nx_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wr_addr_nx_s = '0;
                    rd_addr_nx_s = '0;
                    row_sel_nx_s = '0;
                    if (start) begin
                        next_state_s = ST_PRELOAD;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_PRELOAD: begin
                    if (wr_accept_s) begin
                        bank_sel_nx_s = grp_mask_full_s[NUM_BANKS-1:0];
                        wr_addr_nx_s  = {NUM_BANKS{ADDR_W'(line_cnt_s)}};
                        if (line_all_last_s) begin
                            next_state_s = ST_PRIME;
                        end else begin
                            next_state_s = ST_PRELOAD;
                        end
                    end else begin
                        next_state_s = ST_PRELOAD;
                    end
                end
                ST_PRIME: begin
                    rd_en_n_nx_s = 1'b0;
                    rd_addr_nx_s = {NUM_BANKS{ADDR_W'(prime_cnt_s)}};
                    row_sel_nx_s = RSW'(prime_cnt_s);
                    if (prime_last_s) begin
                        next_state_s = ST_SEARCH;
                    end else begin
                        next_state_s = ST_PRIME;
                    end
                end
                ST_SEARCH: begin
                    if (pe_step) begin
                        rd_en_n_nx_s = 1'b0;
                        rd_addr_nx_s = {NUM_BANKS{search_row_s}};
                        row_sel_nx_s = search_row_s[RSW-1:0];
                        if (step_last_s) begin
                            next_state_s = ST_DONE;
                            done_nx_s    = 1'b1;
                        end else begin
                            next_state_s = ST_SEARCH;
                        end
                    end else begin
                        next_state_s = ST_SEARCH;
                    end
                end
                ST_DONE: begin
                    next_state_s = ST_IDLE;
                    wr_addr_nx_s = '0;
                    rd_addr_nx_s = '0;
                    row_sel_nx_s = '0;
                end
                default: begin
                    next_state_s = ST_IDLE;
                    wr_addr_nx_s = '0;
                    rd_addr_nx_s = '0;
                    row_sel_nx_s = '0;
                end
            endcase
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bank_sel_r <= '0;
            wr_addr_r  <= '0;
            rd_addr_r  <= '0;
            rd_en_n_r  <= 1'b1;
            row_sel_r  <= '0;
            done_r     <= 1'b0;
            wr_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            bank_sel_r <= bank_sel_nx_s;
            wr_addr_r  <= wr_addr_nx_s;
            rd_addr_r  <= rd_addr_nx_s;
            rd_en_n_r  <= rd_en_n_nx_s;
            row_sel_r  <= row_sel_nx_s;
            done_r     <= done_nx_s;
            wr_ready_r <= (next_state_s == ST_PRELOAD);
            busy_r     <= (next_state_s != ST_IDLE);
        end
    end

`ifdef REFMEM_PERF_EN
    logic [15:0] perf_r;

    // Busy-cycle counter; saturates and holds in IDLE so the last job stays readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= 16'h0000;
        end else if (cnt_clr_s) begin
            perf_r <= 16'h0000;
        end else if (busy_r && (perf_r != 16'hFFFF)) begin
            perf_r <= perf_r + 16'h0001;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_cycles = perf_r;
`else
    assign perf_cycles = 16'h0000;
`endif

    assign bank_sel    = bank_sel_r;
    assign wr_addr_all = wr_addr_r;
    assign rd_addr_all = rd_addr_r;
    assign rd_en_n     = rd_en_n_r;
    assign rd_row_sel  = row_sel_r;
    assign done        = done_r;
    assign wr_ready    = wr_ready_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_ref_win_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ref_win_mem_ctrl
// Self-checking bench for ref_win_mem_ctrl (default parameters). Expected
// writes and reads are queued when stimulus is driven and compared when the
// DUT presents them. Whole jobs come from a small vector table; reset during
// preload and abort during search are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_ref_win_mem_ctrl;

    localparam int NB    = 32;
    localparam int AW    = 7;
    localparam int LPG   = 96;
    localparam int RR    = 4;
    localparam int SS    = 64;
    localparam int TOTAL = 768;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic            wr_valid;
    logic            pe_step;
    logic            wr_ready;
    logic [NB-1:0]   bank_sel;
    logic [NB*AW-1:0] wr_addr_all;
    logic [NB*AW-1:0] rd_addr_all;
    logic            rd_en_n;
    logic [1:0]      rd_row_sel;
    logic            busy;
    logic            done;
    logic [15:0]     perf_cycles;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [31:0] sel; logic [6:0] addr; } wr_exp_t;
    typedef struct { logic [6:0] addr; logic [1:0] rsel; } rd_exp_t;
    typedef struct {
        int vmode;      // 0: wr_valid always high, 1: toggles 1,0
        int sper;       // pe_step every sper-th cycle in SEARCH
        bit prime_step; // hold pe_step high during PRIME too
        int exp_wr;
        int exp_rd;
        int exp_perf;
    } vec_t;

    wr_exp_t q_wr[$];
    rd_exp_t q_rd[$];
    int n_wr;
    int n_rd;
    int n_done;

    ref_win_mem_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .pe_step     (pe_step),
        .bank_sel    (bank_sel),
        .wr_addr_all (wr_addr_all),
        .rd_addr_all (rd_addr_all),
        .rd_en_n     (rd_en_n),
        .rd_row_sel  (rd_row_sel),
        .busy        (busy),
        .done        (done),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write/read the DUT shows must match the head of its queue.
    always @(negedge clk) begin
        wr_exp_t we;
        rd_exp_t re;
        if (rst_n === 1'b1) begin
            if (bank_sel != '0) begin
                n_wr++;
                if (q_wr.size() == 0) begin
                    check("spurious_write", {224'd0, bank_sel}, 256'd0);
                end else begin
                    we = q_wr.pop_front();
                    check("wr_bank_sel", {224'd0, bank_sel}, {224'd0, we.sel});
                    check("wr_addr_all", {32'd0, wr_addr_all}, {32'd0, {NB{we.addr}}});
                end
            end
            if (rd_en_n == 1'b0) begin
                n_rd++;
                if (q_rd.size() == 0) begin
                    check("spurious_read", {255'd0, rd_en_n}, 256'd1);
                end else begin
                    re = q_rd.pop_front();
                    check("rd_addr_all", {32'd0, rd_addr_all}, {32'd0, {NB{re.addr}}});
                    check("rd_row_sel", {254'd0, rd_row_sel}, {254'd0, re.rsel});
                end
            end
            if (done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bank_sel"}, {224'd0, bank_sel}, 256'd0);
        check({tag, "_wr_addr"}, {32'd0, wr_addr_all}, 256'd0);
        check({tag, "_rd_addr"}, {32'd0, rd_addr_all}, 256'd0);
        check({tag, "_rd_en_n"}, {255'd0, rd_en_n}, 256'd1);
        check({tag, "_rd_row_sel"}, {254'd0, rd_row_sel}, 256'd0);
        check({tag, "_wr_ready"}, {255'd0, wr_ready}, 256'd0);
        check({tag, "_busy"}, {255'd0, busy}, 256'd0);
        check({tag, "_done"}, {255'd0, done}, 256'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {255'd0, busy}, 256'd1);
        check("wr_ready_after_start", {255'd0, wr_ready}, 256'd1);
        check("perf_clear_on_start", {240'd0, perf_cycles}, 256'd0);
    endtask

    task automatic do_preload(input int vmode, input int n_acc);
        int acc = 0;
        int c = 0;
        while (acc < n_acc && c < 4000) begin
            wr_valid = (vmode == 0) ? 1'b1 : ((c % 2) == 0);
            if (wr_valid) begin
                check("wr_ready_in_preload", {255'd0, wr_ready}, 256'd1);
                q_wr.push_back('{sel: 32'h0000000F << (4 * (acc / LPG)), addr: 7'(acc % LPG)});
                acc++;
            end
            tick();
            c++;
        end
        wr_valid = 1'b0;
        if (acc < n_acc) check("preload_timeout", 256'(acc), 256'(n_acc));
    endtask

    task automatic do_search(input int sper, input bit prime_step, input int nsteps);
        int s = 0;
        int c = 0;
        for (int k = 0; k < RR; k++) q_rd.push_back('{addr: 7'(k), rsel: 2'(k)});
        pe_step = prime_step;
        repeat (RR) tick();
        while (s < nsteps && c < 1000) begin
            pe_step = ((c % sper) == (sper - 1));
            if (pe_step) begin
                q_rd.push_back('{addr: 7'(RR + s), rsel: 2'((RR + s) % RR)});
                s++;
            end
            tick();
            c++;
        end
        pe_step = 1'b0;
        if (s < nsteps) check("search_timeout", 256'(s), 256'(nsteps));
    endtask

    task automatic run_job(input vec_t v);
        n_wr = 0;
        n_rd = 0;
        n_done = 0;
        do_start();
        do_preload(v.vmode, TOTAL);
        check("wr_ready_drop_on_last", {255'd0, wr_ready}, 256'd0);
        check("last_write_sel", {224'd0, bank_sel}, 256'hF0000000);
        check("busy_in_prime", {255'd0, busy}, 256'd1);
        do_search(v.sper, v.prime_step, SS);
        check("done_pulse", {255'd0, done}, 256'd1);
        tick();
        check_idle_outputs("after_done");
`ifdef REFMEM_PERF_EN
        check("perf_cycles", {240'd0, perf_cycles}, 256'(v.exp_perf));
`else
        check("perf_cycles", {240'd0, perf_cycles}, 256'd0);
`endif
        repeat (3) tick();
`ifdef REFMEM_PERF_EN
        check("perf_hold_idle", {240'd0, perf_cycles}, 256'(v.exp_perf));
`endif
        check("job_done_count", 256'(n_done), 256'd1);
        check("job_write_count", 256'(n_wr), 256'(v.exp_wr));
        check("job_read_count", 256'(n_rd), 256'(v.exp_rd));
        check("wr_queue_empty", 256'(q_wr.size()), 256'd0);
        check("rd_queue_empty", 256'(q_rd.size()), 256'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        vecs[0] = '{vmode: 0, sper: 1, prime_step: 1'b1, exp_wr: TOTAL, exp_rd: RR + SS, exp_perf: 837};
        vecs[1] = '{vmode: 1, sper: 3, prime_step: 1'b0, exp_wr: TOTAL, exp_rd: RR + SS, exp_perf: 1732};
        vecs[2] = '{vmode: 1, sper: 1, prime_step: 1'b0, exp_wr: TOTAL, exp_rd: RR + SS, exp_perf: 1604};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        wr_valid = 1'b0;
        pe_step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_perf", {240'd0, perf_cycles}, 256'd0);
        rst_n = 1'b1;
        tick();

        // Reset arriving at line 50 of group 2.
        do_start();
        do_preload(0, 2 * LPG + 50);
        @(negedge clk);
        #1;
        wr_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check("async_reset_perf", {240'd0, perf_cycles}, 256'd0);
        tick();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("queue_after_reset", 256'(q_wr.size()), 256'd0);

        for (int i = 0; i < 3; i++) run_job(vecs[i]);

        // Abort in SEARCH after 10 steps, with pe_step also high on that edge.
        n_done = 0;
        do_start();
        do_preload(0, TOTAL);
        do_search(1, 1'b0, 10);
        abort = 1'b1;
        pe_step = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_idle_outputs("after_abort");
        // wr_valid and pe_step are ignored in IDLE.
        wr_valid = 1'b1;
        repeat (5) tick();
        wr_valid = 1'b0;
        pe_step = 1'b0;
        check_idle_outputs("idle_ignores_inputs");
        check("abort_no_done", 256'(n_done), 256'd0);
        check("abort_rd_queue", 256'(q_rd.size()), 256'd0);

        run_job(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
